mii_frame_monitor: RTL and testbench

Parametrised, byte-accurate successor to the 64-bit MII stream checker. It sits passively on any N-lane MII TX bus, with N = DATA_WIDTH/8. It checks frame framing, payload length and inter-packet gap (IPG) against byte limits set by parameters. It reports per-frame error pulses, the last frame length, and saturating statistics counters for the testbench scoreboard and the debug CSRs.

---
 rtl/mii_pkg.sv | 25 ++
 rtl/mii_lane_classifier.sv | 28 ++
 rtl/mii_frame_monitor.sv | 175 +++++++++++++++++
 tb/tb_mii_frame_monitor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mii_pkg.sv
// Shared definitions for the MII frame monitor: control characters,
// frame-tracking states and the per-lane classification codes.
package mii_pkg;

  localparam logic [7:0] CHAR_IDLE  = 8'h07;
  localparam logic [7:0] CHAR_START = 8'hFB;
  localparam logic [7:0] CHAR_TERM  = 8'hFD;
  localparam logic [7:0] CHAR_ERR   = 8'hFE;

  typedef enum logic [1:0] {
    WAIT_START = 2'd0,
    IN_FRAME   = 2'd1,
    IN_GAP     = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DATA,
    IDLE,
    START,
    TERM,
    ERR,
    OTHER
  } lane_class_t;

endpackage

// File: rtl/mii_lane_classifier.sv
// Combinational decode of every lane of an MII word into a lane_class_t,
// so the monitor FSM only has to reason about character classes.
module mii_lane_classifier
  import mii_pkg::*;
#(
  parameter int         CTRL_WIDTH = 8,
  parameter logic [7:0] IDLE_CODE  = CHAR_IDLE,
  parameter logic [7:0] START_CODE = CHAR_START,
  parameter logic [7:0] TERM_CODE  = CHAR_TERM,
  parameter logic [7:0] ERR_CODE   = CHAR_ERR
) (
  input  logic [8*CTRL_WIDTH-1:0] i_data,
  input  logic [CTRL_WIDTH-1:0]   i_ctrl,
  output lane_class_t             o_lane_class [CTRL_WIDTH]
);

  always_comb begin
    for (int k = 0; k < CTRL_WIDTH; k++) begin
      if (!i_ctrl[k])                          o_lane_class[k] = DATA;
      else if (i_data[8*k +: 8] == IDLE_CODE)  o_lane_class[k] = IDLE;
      else if (i_data[8*k +: 8] == START_CODE) o_lane_class[k] = START;
      else if (i_data[8*k +: 8] == TERM_CODE)  o_lane_class[k] = TERM;
      else if (i_data[8*k +: 8] == ERR_CODE)   o_lane_class[k] = ERR;
      else                                     o_lane_class[k] = OTHER;
    end
  end

endmodule

// File: rtl/mii_frame_monitor.sv
// Passive N-lane MII TX monitor: tracks framing, payload length and
// inter-packet gap in bytes, and keeps saturating frame/error statistics.
module mii_frame_monitor
  import mii_pkg::*;
#(
  parameter int         DATA_WIDTH        = 64,
  parameter int         CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int         MIN_PAYLOAD_BYTES = 40,
  parameter int         MAX_PAYLOAD_BYTES = 136,
  parameter int         MIN_IPG_BYTES     = 16,
  parameter int         MAX_IPG_BYTES     = 40,
  parameter int         CNT_WIDTH         = 16,
  parameter logic [7:0] IDLE_CODE         = CHAR_IDLE,
  parameter logic [7:0] START_CODE        = CHAR_START,
  parameter logic [7:0] TERM_CODE         = CHAR_TERM,
  parameter logic [7:0] ERR_CODE          = CHAR_ERR
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic [CTRL_WIDTH-1:0] i_tx_ctrl,
  input  logic                  i_clear_counts,
  output logic                  o_payload_error,
  output logic                  o_intergap_error,
  output logic                  o_other_error,
  output logic                  o_frame_done,
  output logic [CNT_WIDTH-1:0]  o_frame_len,
  output logic [CNT_WIDTH-1:0]  o_frame_count,
  output logic [CNT_WIDTH-1:0]  o_error_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] PAY_MIN = CNT_WIDTH'(MIN_PAYLOAD_BYTES);
  localparam logic [CNT_WIDTH-1:0] PAY_MAX = CNT_WIDTH'(MAX_PAYLOAD_BYTES);
  localparam logic [CNT_WIDTH-1:0] IPG_MIN = CNT_WIDTH'(MIN_IPG_BYTES);
  localparam logic [CNT_WIDTH-1:0] IPG_MAX = CNT_WIDTH'(MAX_IPG_BYTES);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  lane_class_t w_lane_class [CTRL_WIDTH];

  mii_lane_classifier #(
    .CTRL_WIDTH (CTRL_WIDTH),
    .IDLE_CODE  (IDLE_CODE),
    .START_CODE (START_CODE),
    .TERM_CODE  (TERM_CODE),
    .ERR_CODE   (ERR_CODE)
  ) u_classifier (
    .i_data       (i_tx_data),
    .i_ctrl       (i_tx_ctrl),
    .o_lane_class (w_lane_class)
  );

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_payload_cnt;
  logic [CNT_WIDTH-1:0] r_gap_cnt;
  logic                 r_payload_error;
  logic                 r_intergap_error;
  logic                 r_other_error;
  logic                 r_frame_done;
  logic [CNT_WIDTH-1:0] r_frame_len;
  logic [CNT_WIDTH-1:0] r_frame_count;
  logic [CNT_WIDTH-1:0] r_error_count;

  state_t               w_state;
  logic [CNT_WIDTH-1:0] w_payload_cnt;
  logic [CNT_WIDTH-1:0] w_gap_cnt;
  logic                 w_payload_error;
  logic                 w_intergap_error;
  logic                 w_other_error;
  logic                 w_frame_done;
  logic [CNT_WIDTH-1:0] w_frame_len;
  logic                 w_any_error;

  always_comb begin
    // NOTE: blocking assignments chain lane k's result into lane k+1 within one pass;
    // every variable is defaulted first so no latch can be inferred.
    w_state          = r_state;
    w_payload_cnt    = r_payload_cnt;
    w_gap_cnt        = r_gap_cnt;
    w_payload_error  = 1'b0;
    w_intergap_error = 1'b0;
    w_other_error    = 1'b0;
    w_frame_done     = 1'b0;
    w_frame_len      = r_frame_len;
    for (int k = 0; k < CTRL_WIDTH; k++) begin
      case (w_state)
        WAIT_START: begin
          if (w_lane_class[k] == START && k == 0) begin
            w_state       = IN_FRAME;
            w_payload_cnt = '0;
          end else if (w_lane_class[k] != IDLE) begin
            w_other_error = 1'b1;
          end
        end
        IN_FRAME: begin
          if (w_lane_class[k] == DATA) begin
            w_payload_cnt = sat_inc(w_payload_cnt);
          end else if (w_lane_class[k] == TERM) begin
            // A saturated count is out of range even if the limit is CNT_MAX.
            if (w_payload_cnt < PAY_MIN || w_payload_cnt > PAY_MAX || w_payload_cnt == CNT_MAX)
              w_payload_error = 1'b1;
            w_frame_done = 1'b1;
            w_frame_len  = w_payload_cnt;
            w_gap_cnt    = '0;
            w_state      = IN_GAP;
          end else if (w_lane_class[k] == START && k == 0) begin
            w_other_error = 1'b1;
            w_payload_cnt = '0;
          end else begin
            w_other_error = 1'b1;
          end
        end
        IN_GAP: begin
          if (w_lane_class[k] == IDLE) begin
            w_gap_cnt = sat_inc(w_gap_cnt);
          end else if (w_lane_class[k] == START && k == 0) begin
            if (w_gap_cnt < IPG_MIN || w_gap_cnt > IPG_MAX)
              w_intergap_error = 1'b1;
            w_state       = IN_FRAME;
            w_payload_cnt = '0;
          end else begin
            w_other_error = 1'b1;
          end
        end
        default: w_state = WAIT_START;
      endcase
    end
    w_any_error = w_payload_error | w_intergap_error | w_other_error;
  end

  // NOTE: the async reset clears the working counters too, so a frame cut
  // short by reset leaves no residue in payload or gap accounting.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state          <= WAIT_START;
      r_payload_cnt    <= '0;
      r_gap_cnt        <= '0;
      r_payload_error  <= 1'b0;
      r_intergap_error <= 1'b0;
      r_other_error    <= 1'b0;
      r_frame_done     <= 1'b0;
      r_frame_len      <= '0;
      r_frame_count    <= '0;
      r_error_count    <= '0;
    end else begin
      r_state          <= w_state;
      r_payload_cnt    <= w_payload_cnt;
      r_gap_cnt        <= w_gap_cnt;
      r_payload_error  <= w_payload_error;
      r_intergap_error <= w_intergap_error;
      r_other_error    <= w_other_error;
      r_frame_done     <= w_frame_done;
      r_frame_len      <= w_frame_len;
      if (i_clear_counts) begin
        r_frame_count <= '0;
        r_error_count <= '0;
      end else begin
        if (w_frame_done) r_frame_count <= sat_inc(r_frame_count);
        if (w_any_error)  r_error_count <= sat_inc(r_error_count);
      end
    end
  end

  assign o_payload_error  = r_payload_error;
  assign o_intergap_error = r_intergap_error;
  assign o_other_error    = r_other_error;
  assign o_frame_done     = r_frame_done;
  assign o_frame_len      = r_frame_len;
  assign o_frame_count    = r_frame_count;
  assign o_error_count    = r_error_count;

endmodule

// File: tb/tb_mii_frame_monitor.sv
// Self-checking bench for mii_frame_monitor: a byte-stream reference model
// builds frames and gaps, derives expected per-word results, and scores both widths.
module tb_mii_frame_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        clr;
  logic [63:0] d64;
  logic [7:0]  c64;
  logic [31:0] d32;
  logic [3:0]  c32;
  logic        pe64, ge64, oe64, fd64, pe32, ge32, oe32, fd32;
  logic [15:0] fl64, fc64, ec64, fl32, fc32, ec32;

  mii_frame_monitor #(.DATA_WIDTH(64)) dut64 (
    .clk(clk), .i_rst(rst), .i_tx_data(d64), .i_tx_ctrl(c64), .i_clear_counts(clr),
    .o_payload_error(pe64), .o_intergap_error(ge64), .o_other_error(oe64),
    .o_frame_done(fd64), .o_frame_len(fl64), .o_frame_count(fc64), .o_error_count(ec64)
  );

  mii_frame_monitor #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .i_rst(rst), .i_tx_data(d32), .i_tx_ctrl(c32), .i_clear_counts(clr),
    .o_payload_error(pe32), .o_intergap_error(ge32), .o_other_error(oe32),
    .o_frame_done(fd32), .o_frame_len(fl32), .o_frame_count(fc32), .o_error_count(ec32)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a byte stream plus the events the rules predict for it.
  typedef struct {
    int pos;
    bit term;
    int len;
    bit err;
  } ev_t;

  int          lanes = 8;
  logic [8:0]  q[$];
  ev_t         evq[$];
  bit          gap_valid;
  int          gap_run;
  int          exp_len, exp_fc, exp_ec;
  int          clr_at;

  function automatic void push_idles(input int n);
    for (int i = 0; i < n; i++) q.push_back({1'b1, 8'h07});
    gap_run += n;
  endfunction

  function automatic void push_frame(input int len);
    ev_t e;
    while (q.size() % lanes != 0) push_idles(1);
    if (gap_valid) begin
      e.pos = q.size(); e.term = 1'b0; e.len = 0;
      e.err = (gap_run < 16) || (gap_run > 40);
      evq.push_back(e);
    end
    q.push_back({1'b1, 8'hFB});
    for (int i = 0; i < len; i++) q.push_back({1'b0, 8'($urandom)});
    e.pos = q.size(); e.term = 1'b1; e.len = len;
    e.err = (len < 40) || (len > 136);
    evq.push_back(e);
    q.push_back({1'b1, 8'hFD});
    gap_valid = 1'b1;
    gap_run   = 0;
  endfunction

  task automatic set_idle();
    d64 = {8{8'h07}}; c64 = '1;
    d32 = {4{8'h07}}; c32 = '1;
  endtask

  task automatic drive(input logic [63:0] d, input logic [7:0] c);
    if (lanes == 8) begin d64 = d; c64 = c; end
    else begin d32 = d[31:0]; c32 = c[3:0]; end
    @(posedge clk);
    #1;
  endtask

  task automatic get_out(output logic [3:0] f, output logic [15:0] fl, output logic [15:0] fc,
                         output logic [15:0] ec);
    if (lanes == 8) begin f = {pe64, ge64, oe64, fd64}; fl = fl64; fc = fc64; ec = ec64; end
    else begin f = {pe32, ge32, oe32, fd32}; fl = fl32; fc = fc32; ec = ec32; end
  endtask

  task automatic do_reset();
    set_idle();
    clr = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete(); evq.delete();
    gap_valid = 1'b0; gap_run = 0;
    exp_len = 0; exp_fc = 0; exp_ec = 0; clr_at = -1;
  endtask

  task automatic play_stream(input string tag);
    int nw;
    logic [63:0] d;
    logic [7:0]  c;
    bit e_pe, e_ge, e_fd;
    logic [3:0]  f, exp_f;
    logic [15:0] fl, fc, ec;
    while (q.size() % lanes != 0) push_idles(1);
    nw = q.size() / lanes;
    for (int w = 0; w < nw; w++) begin
      d = '0; c = '0;
      for (int k = 0; k < lanes; k++) {c[k], d[8*k +: 8]} = q.pop_front();
      e_pe = 1'b0; e_ge = 1'b0; e_fd = 1'b0;
      while (evq.size() > 0 && evq[0].pos < (w + 1) * lanes) begin
        if (evq[0].term) begin
          e_fd = 1'b1; e_pe = evq[0].err; exp_len = evq[0].len; exp_fc++;
        end else begin
          e_ge = evq[0].err;
        end
        void'(evq.pop_front());
      end
      if (e_pe || e_ge) exp_ec++;
      clr = (w == clr_at);
      drive(d, c);
      clr = 1'b0;
      if (w == clr_at) begin exp_fc = 0; exp_ec = 0; end
      get_out(f, fl, fc, ec);
      exp_f = {e_pe, e_ge, 1'b0, e_fd};
      n_checks++;
      if (f !== exp_f) begin
        n_fail++;
        $display("FAIL %s w%0d flags{pe,ge,oe,fd}: got %b expected %b", tag, w, f, exp_f);
      end
      n_checks++;
      if (fl !== 16'(exp_len)) begin
        n_fail++;
        $display("FAIL %s w%0d frame_len: got %0d expected %0d", tag, w, fl, exp_len);
      end
      n_checks++;
      if (fc !== 16'(exp_fc)) begin
        n_fail++;
        $display("FAIL %s w%0d frame_count: got %0d expected %0d", tag, w, fc, exp_fc);
      end
      n_checks++;
      if (ec !== 16'(exp_ec)) begin
        n_fail++;
        $display("FAIL %s w%0d error_count: got %0d expected %0d", tag, w, ec, exp_ec);
      end
    end
    clr_at = -1;
  endtask

  task automatic test_reset();
    set_idle();
    clr = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({pe64, ge64, oe64, fd64, fl64, fc64, ec64} !== '0) begin
      n_fail++;
      $display("FAIL reset64 outputs: got %h expected 0", {pe64, ge64, oe64, fd64, fl64, fc64, ec64});
    end
    n_checks++;
    if ({pe32, ge32, oe32, fd32, fl32, fc32, ec32} !== '0) begin
      n_fail++;
      $display("FAIL reset32 outputs: got %h expected 0", {pe32, ge32, oe32, fd32, fl32, fc32, ec32});
    end
    do_reset();
  endtask

  task automatic test_legal_frame();
    lanes = 8;
    push_frame(40);
    play_stream("legal");
  endtask

  task automatic test_short_gap();
    push_idles(8);
    push_frame(40);
    play_stream("short_gap");
  endtask

  task automatic test_payload_limits();
    push_idles(20); push_frame(137);
    push_idles(20); push_frame(136);
    push_idles(20); push_frame(39);
    push_idles(20); push_frame(40);
    play_stream("limits");
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 30; i++) begin
      push_idles($urandom_range(0, 40));
      push_frame($urandom_range(30, 150));
      if (i % 5 == 4) play_stream("random");
    end
  endtask

  task automatic test_framing_faults();
    logic [3:0]  f;
    logic [15:0] fl, fc, ec;
    do_reset();
    lanes = 8;
    drive(64'h01020304050607FB, 8'h01);
    repeat (4) drive(64'hA5A5A5A5A5A5A5A5, 8'h00);
    drive(64'h070707070722FD11, 8'hFA);
    get_out(f, fl, fc, ec);
    n_checks++;
    if ({f, fl, fc, ec} !== {4'b0011, 16'd40, 16'd1, 16'd1}) begin
      n_fail++;
      $display("FAIL data_after_term: got f=%b len=%0d fc=%0d ec=%0d expected f=0011 len=40 fc=1 ec=1",
               f, fl, fc, ec);
    end
    drive(64'h07070707FB070707, 8'hFF);
    get_out(f, fl, fc, ec);
    n_checks++;
    if ({f, fc, ec} !== {4'b0010, 16'd1, 16'd2}) begin
      n_fail++;
      $display("FAIL misaligned_start: got f=%b fc=%0d ec=%0d expected f=0010 fc=1 ec=2", f, fc, ec);
    end
    // The gap kept counting through the misaligned START: 5 + 7 = 12 bytes.
    drive(64'h01020304050607FB, 8'h01);
    get_out(f, fl, fc, ec);
    n_checks++;
    if ({f, ec} !== {4'b0100, 16'd3}) begin
      n_fail++;
      $display("FAIL start_after_misaligned: got f=%b ec=%0d expected f=0100 ec=3", f, ec);
    end
  endtask

  task automatic test_reset_and_clear();
    do_reset();
    lanes = 8;
    drive(64'h01020304050607FB, 8'h01);
    drive(64'h1122334455667788, 8'h00);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({pe64, ge64, oe64, fd64, fl64, fc64, ec64} !== '0) begin
      n_fail++;
      $display("FAIL midframe_reset outputs: got %h expected 0", {pe64, ge64, oe64, fd64, fl64, fc64, ec64});
    end
    do_reset();
    push_idles(3);
    push_frame(40);
    play_stream("post_reset");
    push_idles(20);
    push_frame(50);
    clr_at = evq[evq.size()-1].pos / lanes;
    play_stream("clear");
  endtask

  task automatic test_width_sweep();
    do_reset();
    lanes = 4;
    push_frame(40);
    push_idles(17);
    push_frame(136);
    push_idles(2);
    push_frame(137);
    play_stream("w32");
    lanes = 8;
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    set_idle();
    test_reset();
    test_legal_frame();
    test_short_gap();
    test_payload_limits();
    test_random_traffic();
    test_framing_faults();
    test_reset_and_clear();
    test_width_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
